rob_alloc_ctrl: RTL and testbench
=================================

// Module: rob_alloc_ctrl
// PURPOSE
//  Allocation controller for the 4-wide ROB. Takes the per-slot valid mask of a decoded
//  group (inst_val_to_rob from the instruction checker), decides whether the ROB can accept
//  the whole group, and hands out consecutive ROB indices. Tracks head/tail/occupancy
//  under retire and branch-mispredict squash. Sits between rename/dispatch and the ROB array.
// PARAMETERS
//  ROB_DEPTH  32  ROB entries; power of two, >=8
//  PTR_W      5   log2(ROB_DEPTH)
//  HOLD_CYC   2   dispatch-blocked cycles after a squash (1..15)
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          synchronous active-low reset
//  grp_valid    in   1          front end presents a group this cycle
//  inst_val_in  in   4          per-slot valid mask of the group (slot0 = bit0, oldest)
//  grp_ready    out  1          group accepted when grp_valid & grp_ready
//  alloc_en     out  4          per-slot ROB write enable (= inst_val_in on handshake, else 0)
//  alloc_idx    out  4*PTR_W    per-slot ROB index; slot k at [k*PTR_W +: PTR_W]
//  retire_cnt   in   3          entries retired from head this cycle (0..4)
//  flush        in   1          mispredict squash request
//  flush_ptr    in   PTR_W      ROB index of mispredicted branch; entries younger are killed
//  head_ptr     out  PTR_W      oldest entry
//  tail_ptr     out  PTR_W      next free entry
//  occ_cnt      out  PTR_W+1    occupied entries, 0..ROB_DEPTH
//  rob_full     out  1          occ_cnt == ROB_DEPTH
//  rob_empty    out  1          occ_cnt == 0
//  stall_cyc    out  16         stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): head=tail=0, occ=0, state=RUN, hold counter=0,
//    stall_cyc=0; outputs: grp_ready=0 during reset cycle, alloc_en=0, rob_empty=1, rob_full=0.
//  - n = popcount(inst_val_in). grp_ready = (state==RUN) & ~flush & (ROB_DEPTH-occ >= n).
//    Combinational; no dependency on grp_valid. Group is all-or-nothing.
//  - Compaction: slot k gets idx = tail + popcount(inst_val_in[k-1:0]) mod ROB_DEPTH;
//    invalid slots still drive that value with alloc_en[k]=0. Same-cycle (0 latency).
//  - grp_valid with n=0: handshake completes, nothing allocated, pointers unchanged.
//  - Retire: eff_ret = min(retire_cnt, occ). head += eff_ret mod ROB_DEPTH.
//  - Normal update: tail += n_acc; occ_next = occ + n_acc - eff_ret (alloc + retire same cycle
//    legal, incl. at full and at empty).
//  - Flush (wins over allocation; retire still applied): kill = (tail - flush_ptr - 1) mod
//    ROB_DEPTH; tail <= flush_ptr+1; occ_next = occ - kill - eff_ret. flush_ptr outside
//    [head, tail) is illegal (assertion in sim).
//  - FSM: RUN --flush--> SQUASH (1 cycle, grp_ready=0) --> HOLD (HOLD_CYC cycles, counter,
//    grp_ready=0) --> RUN. flush during SQUASH/HOLD: re-apply pointer update, go to SQUASH,
//    restart hold count. Reset in any state returns to RUN with empty ROB.
//  - Wrap-around uses occ, not pointer compare; head==tail is full iff occ==ROB_DEPTH.
// CONFIGURATION
//  ROB_ALLOC_STATS_EN defined: stall_cyc increments (saturating at 16'hFFFF) each cycle with
//  grp_valid & ~grp_ready; cleared by reset only.
//  Not defined: counter not built, stall_cyc tied to 16'h0000; all else identical.
// STRUCTURE
//  Package rob_pkg: ROB_DEPTH, PTR_W, GROUP_W=4, rob_ptr_t, rob_cnt_t, alloc_state_e
//  {RUN,SQUASH,HOLD}; shared with ROB array and retire unit.
//  Sub-module alloc_prefix4: 4-bit mask -> per-slot prefix counts + total n (pure comb).
// TESTING (ROB_DEPTH=32, HOLD_CYC=2)
//  1 Reset, grp_valid=1 mask 4'b1111 x8 -> idx 0..31 in order, occ=32, rob_full=1, 9th group
//    grp_ready=0; with STATS_EN stall_cyc counts 1/cycle.
//  2 Empty ROB, mask 4'b1010 -> alloc_en=1010, slot1 idx0, slot3 idx1; tail=2, occ=2.
//  3 Wrap: head=tail=30 occ=0, mask 1111 -> idx 30,31,0,1; tail=2, occ=4.
//  4 Full (occ=32) + retire_cnt=4 + mask 1111 same cycle -> grp_ready=0 (occ-based),
//    next cycle occ=28, then group accepted; retire_cnt=4 at occ=2 -> occ=0, head+=2.
//  5 head=0 tail=20 occ=20, flush flush_ptr=5 retire_cnt=2 -> tail=6, head=2, occ=4;
//    grp_ready=0 for 3 cycles (SQUASH+2 HOLD), then 1.
//  6 rst_n=0 during HOLD -> next cycle RUN, head=tail=0, occ=0, grp_ready=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB sizing, pointer/count types and allocation FSM states for the
// allocator, ROB array and retire unit.
package rob_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int PTR_W     = $clog2(ROB_DEPTH);
  localparam int GROUP_W   = 4;

  typedef logic [PTR_W-1:0] rob_ptr_t;
  typedef logic [PTR_W:0]   rob_cnt_t;

  typedef enum logic [1:0] {RUN, SQUASH, HOLD} alloc_state_e;
endpackage

// File: rtl/alloc_prefix4.sv
// Group-mask compaction helper: slot k gets the count of valid slots older than
// it; total_o is the group size n. Purely combinational.
module alloc_prefix4
  import rob_pkg::*;
(
  input  logic [GROUP_W-1:0]      mask_i,
  output logic [GROUP_W-1:0][2:0] pre_o,
  output logic [2:0]              total_o
);
  always_comb begin
    pre_o = '0;
    for (int k = 1; k < GROUP_W; k++)
      pre_o[k] = pre_o[k-1] + {2'b00, mask_i[k-1]};
    total_o = pre_o[GROUP_W-1] + {2'b00, mask_i[GROUP_W-1]};
  end
endmodule

// File: rtl/rob_alloc_ctrl.sv
// 4-wide ROB allocation controller: all-or-nothing group acceptance, compacted
// index hand-out, head/tail/occupancy under retire and squash.
// Optional stall-cycle counter built only when ROB_ALLOC_STATS_EN is defined.
module rob_alloc_ctrl
  import rob_pkg::*;
#(
  parameter int HOLD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     grp_valid,
  input  logic [GROUP_W-1:0]       inst_val_in,
  output logic                     grp_ready,
  output logic [GROUP_W-1:0]       alloc_en,
  output logic [GROUP_W*PTR_W-1:0] alloc_idx,
  input  logic [2:0]               retire_cnt,
  input  logic                     flush,
  input  logic [PTR_W-1:0]         flush_ptr,
  output logic [PTR_W-1:0]         head_ptr,
  output logic [PTR_W-1:0]         tail_ptr,
  output logic [PTR_W:0]           occ_cnt,
  output logic                     rob_full,
  output logic                     rob_empty,
  output logic [15:0]              stall_cyc
);
  logic [GROUP_W-1:0][2:0] pre;
  logic [2:0]   n, eff_ret;
  rob_ptr_t     head_q, head_d, tail_q, tail_d, kill;
  rob_cnt_t     occ_q, occ_d, free, n_acc;
  alloc_state_e state_q, state_d;
  logic [3:0]   hold_q, hold_d;
  logic         hs;

  alloc_prefix4 u_prefix (.mask_i(inst_val_in), .pre_o(pre), .total_o(n));

  assign free      = rob_cnt_t'(ROB_DEPTH) - occ_q;
  assign grp_ready = rst_n & (state_q == RUN) & ~flush & (free >= rob_cnt_t'(n));
  assign hs        = grp_valid & grp_ready;
  assign n_acc     = hs ? rob_cnt_t'(n) : '0;
  assign alloc_en  = hs ? inst_val_in : '0;

  for (genvar k = 0; k < GROUP_W; k++) begin : g_idx
    assign alloc_idx[k*PTR_W +: PTR_W] = tail_q + rob_ptr_t'(pre[k]);
  end

  // Occupancy, not pointer equality, disambiguates full from empty.
  assign eff_ret = (rob_cnt_t'(retire_cnt) > occ_q) ? occ_q[2:0] : retire_cnt;
  assign kill    = tail_q - flush_ptr - rob_ptr_t'(1);

  always_comb begin
    head_d = head_q + rob_ptr_t'(eff_ret);
    tail_d = tail_q + rob_ptr_t'(n_acc);
    occ_d  = occ_q + n_acc - rob_cnt_t'(eff_ret);
    if (flush) begin
      tail_d = flush_ptr + rob_ptr_t'(1);
      occ_d  = occ_q - rob_cnt_t'(kill) - rob_cnt_t'(eff_ret);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN:    ;
      SQUASH: begin
        state_d = HOLD;
        hold_d  = 4'(HOLD_CYC - 1);
      end
      HOLD: begin
        if (hold_q == '0) state_d = RUN;
        else              hold_d  = hold_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
    // A squash from any state restarts the blocking window.
    if (flush) begin
      state_d = SQUASH;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      state_q <= RUN;
      hold_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign head_ptr  = head_q;
  assign tail_ptr  = tail_q;
  assign occ_cnt   = occ_q;
  assign rob_full  = (occ_q == rob_cnt_t'(ROB_DEPTH));
  assign rob_empty = (occ_q == '0);

`ifdef ROB_ALLOC_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                        stall_q <= '0;
    else if (grp_valid && !grp_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cyc = stall_q;
`else
  assign stall_cyc = 16'h0000;
`endif

  // A squash point must name a live entry.
  a_flush_legal: assert property (@(posedge clk) disable iff (!rst_n)
    flush |-> (rob_cnt_t'(rob_ptr_t'(flush_ptr - head_q)) < occ_q));
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Self-checking bench for rob_alloc_ctrl: directed scenarios plus randomized
// traffic against a queue-based model of ROB contents.
module tb_rob_alloc_ctrl;
  localparam int D = 32, PW = 5, HOLD = 2;

  logic clk = 1'b0;
  logic rst_n, grp_valid, flush;
  logic [3:0] inst_val_in;
  logic [2:0] retire_cnt;
  logic [PW-1:0] flush_ptr;
  logic grp_ready, rob_full, rob_empty;
  logic [3:0] alloc_en;
  logic [4*PW-1:0] alloc_idx;
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [PW:0] occ_cnt;
  logic [15:0] stall_cyc;

  int checks = 0, errors = 0;
  int mq[$];
  int m_head, m_tail, m_block, m_stall;

  always #5 clk = ~clk;

  rob_alloc_ctrl #(.HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .grp_valid(grp_valid), .inst_val_in(inst_val_in),
    .grp_ready(grp_ready), .alloc_en(alloc_en), .alloc_idx(alloc_idx),
    .retire_cnt(retire_cnt), .flush(flush), .flush_ptr(flush_ptr),
    .head_ptr(head_ptr), .tail_ptr(tail_ptr), .occ_cnt(occ_cnt),
    .rob_full(rob_full), .rob_empty(rob_empty), .stall_cyc(stall_cyc));

  function automatic int pc(input logic [3:0] m, input int upto);
    int c = 0;
    for (int i = 0; i < upto; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic bit m_ready();
    return rst_n && m_block == 0 && !flush && (D - mq.size() >= pc(inst_val_in, 4));
  endfunction

  function automatic logic [4*PW-1:0] m_idx();
    logic [4*PW-1:0] e;
    e = '0;
    for (int k = 0; k < 4; k++) e[k*PW +: PW] = PW'((m_tail + pc(inst_val_in, k)) % D);
    return e;
  endfunction

  task automatic set_in(input bit v, input logic [3:0] m, input int r, input bit fl, input int fp);
    grp_valid = v; inst_val_in = m; retire_cnt = 3'(r); flush = fl; flush_ptr = PW'(fp);
    #1;
  endtask

  // Advance one clock and move the model by the ROB rules.
  task automatic tick();
    bit rdy;
    int eff, n;
    rdy = m_ready();
    n = pc(inst_val_in, 4);
    if (!rst_n) begin
      mq.delete(); m_head = 0; m_tail = 0; m_block = 0; m_stall = 0;
    end else begin
      if (grp_valid && !rdy && m_stall < 65535) m_stall++;
      eff = (int'(retire_cnt) < mq.size()) ? int'(retire_cnt) : mq.size();
      if (flush) begin
        while (mq.size() > 0 && mq[mq.size()-1] != int'(flush_ptr)) void'(mq.pop_back());
        m_tail = (int'(flush_ptr) + 1) % D;
        m_block = HOLD + 1;
      end else begin
        if (m_block > 0) m_block--;
        if (grp_valid && rdy)
          for (int i = 0; i < n; i++) begin mq.push_back(m_tail); m_tail = (m_tail + 1) % D; end
      end
      for (int i = 0; i < eff; i++) void'(mq.pop_front());
      m_head = (m_head + eff) % D;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 4'b0000, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 4'b1111, 0, 0, 0);
    checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", grp_ready); end
    checks++; if (alloc_en !== 4'b0) begin errors++; $display("FAIL reset_alloc_en got %b want 0000", alloc_en); end
    tick();
    set_in(0, 4'b0000, 0, 0, 0);
    checks++; if (head_ptr !== 5'd0 || tail_ptr !== 5'd0 || occ_cnt !== 6'd0)
      begin errors++; $display("FAIL reset_ptrs got h%0d t%0d o%0d want 0 0 0", head_ptr, tail_ptr, occ_cnt); end
    checks++; if (rob_empty !== 1'b1 || rob_full !== 1'b0 || stall_cyc !== 16'h0)
      begin errors++; $display("FAIL reset_flags got e%b f%b s%0d want 1 0 0", rob_empty, rob_full, stall_cyc); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fill();
    logic [4*PW-1:0] e;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      set_in(1, 4'b1111, 0, 0, 0);
      for (int k = 0; k < 4; k++) e[k*PW +: PW] = PW'(4*g + k);
      checks++; if (grp_ready !== 1'b1 || alloc_en !== 4'b1111 || alloc_idx !== e)
        begin errors++; $display("FAIL fill_grp%0d got r%b en%b idx%h want 1 1111 %h", g, grp_ready, alloc_en, alloc_idx, e); end
      tick();
    end
    checks++; if (occ_cnt !== 6'd32 || rob_full !== 1'b1 || head_ptr !== tail_ptr)
      begin errors++; $display("FAIL fill_full got o%0d f%b h%0d t%0d want 32 1 h==t", occ_cnt, rob_full, head_ptr, tail_ptr); end
    set_in(1, 4'b1111, 0, 0, 0);
    checks++; if (grp_ready !== 1'b0 || alloc_en !== 4'b0000)
      begin errors++; $display("FAIL fill_9th got r%b en%b want 0 0000", grp_ready, alloc_en); end
    tick(); tick(); tick();
`ifdef ROB_ALLOC_STATS_EN
    checks++; if (stall_cyc !== 16'd3) begin errors++; $display("FAIL fill_stall got %0d want 3", stall_cyc); end
`else
    checks++; if (stall_cyc !== 16'd0) begin errors++; $display("FAIL fill_stall got %0d want 0", stall_cyc); end
`endif
  endtask

  task automatic test_compact();
    do_reset();
    set_in(1, 4'b1010, 0, 0, 0);
    checks++; if (alloc_en !== 4'b1010 || alloc_idx[1*PW +: PW] !== 5'd0 || alloc_idx[3*PW +: PW] !== 5'd1)
      begin errors++; $display("FAIL compact got en%b s1=%0d s3=%0d want 1010 0 1", alloc_en, alloc_idx[1*PW +: PW], alloc_idx[3*PW +: PW]); end
    tick();
    set_in(0, 4'b0000, 0, 0, 0);
    checks++; if (tail_ptr !== 5'd2 || occ_cnt !== 6'd2)
      begin errors++; $display("FAIL compact_upd got t%0d o%0d want 2 2", tail_ptr, occ_cnt); end
    set_in(1, 4'b0000, 0, 0, 0);
    checks++; if (grp_ready !== 1'b1 || alloc_en !== 4'b0000)
      begin errors++; $display("FAIL empty_grp got r%b en%b want 1 0000", grp_ready, alloc_en); end
    tick();
    checks++; if (tail_ptr !== 5'd2 || occ_cnt !== 6'd2)
      begin errors++; $display("FAIL empty_grp_upd got t%0d o%0d want 2 2", tail_ptr, occ_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int g = 0; g < 7; g++) begin set_in(1, 4'b1111, 0, 0, 0); tick(); end
    set_in(1, 4'b0011, 0, 0, 0); tick();
    for (int g = 0; g < 7; g++) begin set_in(0, 4'b0000, 4, 0, 0); tick(); end
    set_in(0, 4'b0000, 2, 0, 0); tick();
    set_in(1, 4'b1111, 0, 0, 0);
    checks++; if (head_ptr !== 5'd30 || tail_ptr !== 5'd30 || occ_cnt !== 6'd0 || rob_empty !== 1'b1)
      begin errors++; $display("FAIL wrap_pre got h%0d t%0d o%0d want 30 30 0", head_ptr, tail_ptr, occ_cnt); end
    checks++; if (alloc_idx !== {5'd1, 5'd0, 5'd31, 5'd30})
      begin errors++; $display("FAIL wrap_idx got %h want %h", alloc_idx, {5'd1, 5'd0, 5'd31, 5'd30}); end
    tick();
    checks++; if (tail_ptr !== 5'd2 || occ_cnt !== 6'd4)
      begin errors++; $display("FAIL wrap_upd got t%0d o%0d want 2 4", tail_ptr, occ_cnt); end
  endtask

  task automatic test_full_retire();
    do_reset();
    for (int g = 0; g < 8; g++) begin set_in(1, 4'b1111, 0, 0, 0); tick(); end
    set_in(1, 4'b1111, 4, 0, 0);
    checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL full_ret_ready got %b want 0", grp_ready); end
    tick();
    set_in(1, 4'b1111, 0, 0, 0);
    checks++; if (occ_cnt !== 6'd28 || grp_ready !== 1'b1)
      begin errors++; $display("FAIL full_ret_next got o%0d r%b want 28 1", occ_cnt, grp_ready); end
    tick();
    for (int g = 0; g < 7; g++) begin set_in(0, 4'b0000, 4, 0, 0); tick(); end
    set_in(0, 4'b0000, 2, 0, 0); tick();
    set_in(0, 4'b0000, 4, 0, 0);
    checks++; if (occ_cnt !== 6'd2 || head_ptr !== 5'd2)
      begin errors++; $display("FAIL over_ret_pre got o%0d h%0d want 2 2", occ_cnt, head_ptr); end
    tick();
    checks++; if (occ_cnt !== 6'd0 || head_ptr !== 5'd4 || rob_empty !== 1'b1)
      begin errors++; $display("FAIL over_ret got o%0d h%0d want 0 4", occ_cnt, head_ptr); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int g = 0; g < 5; g++) begin set_in(1, 4'b1111, 0, 0, 0); tick(); end
    set_in(1, 4'b1111, 2, 1, 5);
    checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", grp_ready); end
    tick();
    set_in(1, 4'b0001, 0, 0, 0);
    checks++; if (tail_ptr !== 5'd6 || head_ptr !== 5'd2 || occ_cnt !== 6'd4)
      begin errors++; $display("FAIL flush_upd got t%0d h%0d o%0d want 6 2 4", tail_ptr, head_ptr, occ_cnt); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL flush_block%0d got %b want 0", c, grp_ready); end
      tick();
    end
    checks++; if (grp_ready !== 1'b1 || alloc_idx[0 +: PW] !== 5'd6)
      begin errors++; $display("FAIL flush_resume got r%b idx%0d want 1 6", grp_ready, alloc_idx[0 +: PW]); end
    tick();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    set_in(1, 4'b1111, 0, 0, 0); tick();
    set_in(0, 4'b0000, 0, 1, 0); tick();
    set_in(0, 4'b0000, 0, 0, 0); tick();
    rst_n = 1'b0;
    set_in(1, 4'b0001, 0, 0, 0);
    checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL hold_rst_ready got %b want 0", grp_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (grp_ready !== 1'b1 || head_ptr !== 5'd0 || tail_ptr !== 5'd0 || occ_cnt !== 6'd0)
      begin errors++; $display("FAIL hold_rst got r%b h%0d t%0d o%0d want 1 0 0 0", grp_ready, head_ptr, tail_ptr, occ_cnt); end
    tick();
  endtask

  task automatic test_random();
    int pos, r, lim;
    bit fl, v;
    logic [3:0] m;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      m = 4'($urandom);
      fl = (mq.size() > 0) && ($urandom_range(0, 11) == 0);
      pos = 0;
      if (fl) begin
        pos = $urandom_range(0, mq.size() - 1);
        lim = (pos + 1 < 4) ? pos + 1 : 4;
        r = $urandom_range(0, lim);
        pos = mq[pos];
      end else r = $urandom_range(0, 4);
      set_in(v, m, r, fl, pos);
      checks++; if (grp_ready !== m_ready())
        begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, grp_ready, m_ready()); end
      checks++; if (alloc_en !== ((v && m_ready()) ? m : 4'b0000) || alloc_idx !== m_idx())
        begin errors++; $display("FAIL rnd_alloc c%0d got en%b idx%h want idx%h", c, alloc_en, alloc_idx, m_idx()); end
      tick();
      checks++; if (int'(head_ptr) != m_head || int'(tail_ptr) != m_tail || int'(occ_cnt) != mq.size())
        begin errors++; $display("FAIL rnd_state c%0d got h%0d t%0d o%0d want %0d %0d %0d", c, head_ptr, tail_ptr, occ_cnt, m_head, m_tail, mq.size()); end
      checks++; if (rob_full !== (mq.size() == D) || rob_empty !== (mq.size() == 0))
        begin errors++; $display("FAIL rnd_flags c%0d got f%b e%b", c, rob_full, rob_empty); end
`ifdef ROB_ALLOC_STATS_EN
      checks++; if (int'(stall_cyc) != m_stall) begin errors++; $display("FAIL rnd_stall got %0d want %0d", stall_cyc, m_stall); end
`else
      checks++; if (stall_cyc !== 16'h0) begin errors++; $display("FAIL rnd_stall got %0d want 0", stall_cyc); end
`endif
    end
  endtask

  initial begin
    mq.delete(); m_head = 0; m_tail = 0; m_block = 0; m_stall = 0;
    rst_n = 1'b0;
    set_in(0, 4'b0000, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_compact();
    test_wrap();
    test_full_retire();
    test_flush();
    test_reset_in_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
